// File: rtl/ram_pkg.sv
// Constants shared by the port-B burst reader and the dual-port RAM it drives:
// default widths and the reader FSM state encoding.
package ram_pkg;

    localparam int DATA_WIDTH_DEF = 7;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int RAM_LOC_DEF    = 63;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/dual_port_ram.sv
// Dual-port RAM with synchronous writes and combinational reads on both ports.
// Read data follows the address within the same cycle, so a registered address is seen one edge later.
module Dual_Port_RAM
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RAM_LOC    = RAM_LOC_DEF
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH:0]   data_A,
    input  logic [DATA_WIDTH:0]   data_B,
    input  logic [ADDR_WIDTH:0]   addr_A,
    input  logic [ADDR_WIDTH:0]   addr_B,
    input  logic                  w_A,
    input  logic                  w_B,
    output logic [DATA_WIDTH:0]   q_A,
    output logic [DATA_WIDTH:0]   q_B
);

    logic [DATA_WIDTH:0] mem [0:RAM_LOC];

    always_ff @(posedge clk) begin
        if (w_A) begin
            mem[addr_A] <= data_A;
        end
        if (w_B) begin
            mem[addr_B] <= data_B;
        end
    end

    assign q_A = mem[addr_A];
    assign q_B = mem[addr_B];

endmodule

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO of {last, data} words between RAM capture and the output stream.
// Entry 0 is always the head, so the output holds still until it is popped.
module ram_rd_skid
    import ram_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             valid
);

    logic [WIDTH-1:0] e0_reg, e1_reg, e0_next, e1_next;
    logic [1:0]       count_reg, count_next;
    logic             pop_eff, push_eff;

    always_comb begin
        pop_eff    = pop && (count_reg != 2'd0);
        // A push into a full buffer is only taken when the head leaves in the same cycle.
        push_eff   = push && ((count_reg != 2'd2) || pop_eff);
        e0_next    = e0_reg;
        e1_next    = e1_reg;
        count_next = count_reg;
        case ({push_eff, pop_eff})
            2'b10: begin
                if (count_reg == 2'd0) begin
                    e0_next = push_data;
                end else begin
                    e1_next = push_data;
                end
                count_next = count_reg + 2'd1;
            end
            2'b01: begin
                e0_next    = e1_reg;
                count_next = count_reg - 2'd1;
            end
            2'b11: begin
                if (count_reg == 2'd1) begin
                    e0_next = push_data;
                end else begin
                    e0_next = e1_reg;
                    e1_next = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_reg    <= '0;
            e1_reg    <= '0;
            count_reg <= 2'd0;
        end else begin
            e0_reg    <= e0_next;
            e1_reg    <= e1_next;
            count_reg <= count_next;
        end
    end

    assign head  = e0_reg;
    assign count = count_reg;
    assign valid = (count_reg != 2'd0);

endmodule

// File: rtl/ram_burst_reader.sv
// Port-B burst read master: takes {start, length-1} commands and streams the RAM words
// out with a last marker, throttling reads so the two-entry output buffer never overflows.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RAM_LOC    = RAM_LOC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_WIDTH:0] cmd_addr,
    input  logic [ADDR_WIDTH:0] cmd_len,
    output logic [ADDR_WIDTH:0] addr_B,
    output logic                w_B,
    input  logic [DATA_WIDTH:0] q_B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WIDTH:0] out_data,
    output logic                out_last,
    output logic                busy
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = RAM_LOC[ADDR_WIDTH:0];

    logic [1:0]            state_reg;
    logic [ADDR_WIDTH:0]   counter_reg, remaining_reg, addr_reg, counter_next;
    logic                  inflight_reg, inflight_last_reg;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH+1:0] skid_head;
    logic                  skid_valid, pop, issue;
    logic [2:0]            occupancy;

    always_comb begin
        pop          = skid_valid && out_ready;
        // Buffer occupancy just after this edge; the word issued now lands one edge later.
        occupancy    = {1'b0, skid_count} + {2'b00, inflight_reg} - {2'b00, pop};
        issue        = (state_reg == ST_RUN) && (occupancy < 3'd2);
        counter_next = (counter_reg == LAST_ADDR) ? '0
                                                  : counter_reg + (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            counter_reg       <= '0;
            remaining_reg     <= '0;
            addr_reg          <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (remaining_reg == '0);
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        counter_reg   <= cmd_addr;
                        remaining_reg <= cmd_len;
                        state_reg     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_reg      <= counter_reg;
                        counter_reg   <= counter_next;
                        remaining_reg <= remaining_reg - (ADDR_WIDTH+1)'(1);
                        if (remaining_reg == '0) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && skid_head[DATA_WIDTH+1]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    ram_rd_skid #(
        .WIDTH(DATA_WIDTH + 2)
    ) skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_reg),
        .push_data({inflight_last_reg, q_B}),
        .pop      (pop),
        .head     (skid_head),
        .count    (skid_count),
        .valid    (skid_valid)
    );

    assign addr_B    = addr_reg;
    assign w_B       = 1'b0;
    assign out_valid = skid_valid;
    assign out_data  = skid_head[DATA_WIDTH:0];
    assign out_last  = skid_valid && skid_head[DATA_WIDTH+1];
    assign busy      = (state_reg != ST_IDLE);
    assign cmd_ready = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed and random bursts through ram_burst_reader backed by Dual_Port_RAM,
// checked against a word-level model of the RAM contents.
module tb_ram_burst_reader;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [5:0] cmd_addr, cmd_len;
    logic [5:0] addr_b;
    logic       w_b;
    logic [7:0] q_b;
    logic       out_valid, out_ready, out_last, busy;
    logic [7:0] out_data;
    logic [5:0] addr_a;
    logic [7:0] data_a, data_b, q_a;
    logic       w_a;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [0:63];

    ram_burst_reader dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .addr_B   (addr_b),
        .w_B      (w_b),
        .q_B      (q_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    Dual_Port_RAM ram (
        .clk   (clk),
        .data_A(data_a),
        .data_B(data_b),
        .addr_A(addr_a),
        .addr_B(addr_b),
        .w_A   (w_a),
        .w_B   (w_b),
        .q_A   (q_a),
        .q_B   (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_addr_B"},    32'(addr_b),    32'd0);
        chk({tag, "_w_B"},       32'(w_b),       32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    // Fill the RAM through port A; rand_fill selects random contents instead of a+3.
    task automatic preload(input bit rand_fill);
        for (int a = 0; a < 64; a++) begin
            addr_a     = a[5:0];
            data_a     = rand_fill ? 8'($urandom) : 8'(a + 3);
            w_a        = 1'b1;
            ref_mem[a] = data_a;
            @(negedge clk);
        end
        w_a = 1'b0;
    endtask

    // mode 0: out_ready always high; 1: random 50%; 2: low on relative cycles 3..7.
    // hold keeps cmd_valid asserted for the whole burst.
    task automatic run_burst(input int a, input int l, input int mode, input bit hold);
        int         n, got, issued, rel, k;
        int         exp_a [64];
        logic [7:0] exp_d [64];
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;

        n = l + 1;
        for (int i = 0; i < n; i++) begin
            exp_a[i] = (a + i) % 64;
            exp_d[i] = ref_mem[exp_a[i]];
        end
        cmd_addr  = 6'(a);
        cmd_len   = 6'(l);
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;

        got = 0; issued = 0; rel = 0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (got < n && rel < 400) begin
            chk("w_B_low", 32'(w_b), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
            chk("cmd_ready_low", 32'(cmd_ready), 32'd0);
            if (issued < n && int'(addr_b) == exp_a[issued]) issued++;
            chk("outstanding_bound", 32'(issued - got <= 3), 32'd1);
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (mode == 0) chk("throughput_valid", 32'(out_valid), 32'(rel >= 2));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(rel >= 3 && rel <= 7);
            endcase
            if (out_valid && out_ready) begin
                chk("word_data", 32'(out_data), 32'(exp_d[got]));
                chk("word_last", 32'(out_last), 32'(got == n - 1));
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            @(negedge clk);
            rel++;
        end
        chk("word_count", 32'(got), 32'(n));
        chk("addr_sequence", 32'(issued), 32'(n));
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        $display("burst addr=%0d len=%0d mode=%0d hold=%0d words=%0d cycles=%0d",
                 a, l, mode, hold, got, rel);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
        w_a = 1'b0; addr_a = '0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);

        preload(1'b0);
        run_burst(0, 7, 0, 1'b0);
        run_burst(62, 3, 0, 1'b0);
        run_burst(4, 5, 2, 1'b0);
        run_burst(9, 0, 0, 1'b1);

        // Reset while the third word of a 16-word burst is on the output.
        cmd_addr = 6'd0; cmd_len = 6'd15; cmd_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_word", 32'(out_data), 32'(ref_mem[2]));
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("post_rst");
        $display("reset mid-burst applied");
        run_burst(20, 1, 0, 1'b0);

        preload(1'b1);
        for (int b = 0; b < 20; b++) begin
            run_burst(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), 1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
